// File: rtl/microwave_timer.sv
// Microwave cook-time countdown: four BCD digits (MM:SS) entered from the keypad,
// decremented once per prescaler period while the magnetron is enabled.
module microwave_timer #(
    parameter int unsigned TICKS_PER_SEC = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clearn,
    input  logic       load,
    input  logic [3:0] digit,
    input  logic       mag_on,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done,
    output logic       done_pulse
);

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    localparam logic [1:0] EMPTY   = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] RUNNING = 2'd2;

    logic [1:0]    state, state_next;
    logic [PW-1:0] presc;
    logic          count_en, tick, load_ok, last_second, next_zero;
    logic          b_so, b_st, b_mo;
    logic [3:0]    dec_so, dec_st, dec_mo, dec_mt;
    logic [3:0]    mt_n, mo_n, st_n, so_n;

    // BCD borrow chain; sec_tens 6..9 (as keyed in) simply count down
    always_comb begin
        b_so   = (sec_ones == 4'd0);
        dec_so = b_so ? 4'd9 : sec_ones - 4'd1;
        b_st   = b_so && (sec_tens == 4'd0);
        dec_st = b_so ? ((sec_tens == 4'd0) ? 4'd5 : sec_tens - 4'd1) : sec_tens;
        b_mo   = b_st && (min_ones == 4'd0);
        dec_mo = b_st ? ((min_ones == 4'd0) ? 4'd9 : min_ones - 4'd1) : min_ones;
        dec_mt = b_mo ? min_tens - 4'd1 : min_tens;
    end

    always_comb begin
        count_en    = mag_on && (state != EMPTY);
        tick        = count_en && (presc == PRESC_MAX);
        load_ok     = load && !mag_on && (digit <= 4'd9);
        last_second = ({min_tens, min_ones, sec_tens} == 12'd0) && (sec_ones == 4'd1);

        mt_n = min_tens;
        mo_n = min_ones;
        st_n = sec_tens;
        so_n = sec_ones;
        if (tick) begin
            mt_n = dec_mt;
            mo_n = dec_mo;
            st_n = dec_st;
            so_n = dec_so;
        end else if (load_ok) begin
            mt_n = min_ones;
            mo_n = sec_tens;
            st_n = sec_ones;
            so_n = digit;
        end

        next_zero = ({mt_n, mo_n, st_n, so_n} == 16'd0);
        if (next_zero)
            state_next = EMPTY;
        else if (mag_on)
            state_next = RUNNING;
        else
            state_next = ARMED;
    end

    always_ff @(posedge clk) begin
        if (reset || !clearn) begin
            min_tens   <= '0;
            min_ones   <= '0;
            sec_tens   <= '0;
            sec_ones   <= '0;
            presc      <= '0;
            state      <= EMPTY;
            done_pulse <= 1'b0;
        end else begin
            min_tens   <= mt_n;
            min_ones   <= mo_n;
            sec_tens   <= st_n;
            sec_ones   <= so_n;
            state      <= state_next;
            done_pulse <= tick && last_second;
            // Entering EMPTY (even via a load that shifts to 00:00) drops any partial second
            if (next_zero)
                presc <= '0;
            else if (count_en)
                presc <= tick ? '0 : presc + PW'(1);
        end
    end

    assign timer_done = ({min_tens, min_ones, sec_tens, sec_ones} == 16'd0);

endmodule
